// File: rtl/pipeline_ctrl.sv
// Hazard control for a 5-stage in-order pipeline: memory-wait freeze, branch
// flush, load-use stall, operand forwarding, plus timeout and stall statistics.
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_dm_rd,
    input  logic [4:0]  me_rd,
    input  logic        me_ru_wr,
    input  logic [4:0]  wb_rd,
    input  logic        wb_ru_wr,
    input  logic        ex_branch_taken,
    input  logic        me_dm_req,
    input  logic        dm_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_me_en,
    output logic        me_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        me_wb_bubble,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mem_err,
    output logic [31:0] stall_cycles
);

    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    typedef struct packed {
        logic pc, if_id, id_ex, ex_me, me_wb;
    } en_t;

    typedef struct packed {
        logic if_id, id_ex, me_wb;
    } flush_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       mem_stall, br_flush, lu_stall;
    en_t        en;
    flush_t     fl;

    assign mem_stall = me_dm_req && !dm_ready;
    assign br_flush  = ex_branch_taken && !mem_stall;
    assign lu_stall  = ex_dm_rd && (ex_rd != 5'd0) &&
                       ((ex_rd == id_rs1) || (ex_rd == id_rs2)) &&
                       !mem_stall && !br_flush;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] mrd, input logic mwr,
                                           input logic [4:0] wrd, input logic wwr);
        if (mwr && (mrd != 5'd0) && (mrd == rs))      return 2'b10;
        else if (wwr && (wrd != 5'd0) && (wrd == rs)) return 2'b01;
        else                                          return 2'b00;
    endfunction

    // Everything is forced quiet while reset is held, independent of inputs.
    always_comb begin
        en    = '0;
        fl    = '0;
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (rst_n) begin
            en    = '1;
            fwd_a = fwd_sel(ex_rs1, me_rd, me_ru_wr, wb_rd, wb_ru_wr);
            fwd_b = fwd_sel(ex_rs2, me_rd, me_ru_wr, wb_rd, wb_ru_wr);
            if (mem_stall) begin
                en       = '0;
                en.me_wb = 1'b1;
                fl.me_wb = 1'b1;
            end else if (br_flush) begin
                fl.if_id = 1'b1;
                fl.id_ex = 1'b1;
            end else if (lu_stall) begin
                en.pc    = 1'b0;
                en.if_id = 1'b0;
                fl.id_ex = 1'b1;
            end
        end
    end

    assign pc_en        = en.pc;
    assign if_id_en     = en.if_id;
    assign id_ex_en     = en.id_ex;
    assign ex_me_en     = en.ex_me;
    assign me_wb_en     = en.me_wb;
    assign if_id_flush  = fl.if_id;
    assign id_ex_flush  = fl.id_ex;
    assign me_wb_bubble = fl.me_wb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (dm_ready) begin
                        state    <= RUN;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
                        // Give up on the access; the error is sticky until reset.
                        state    <= RUN;
                        wait_cnt <= 8'd0;
                        mem_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= 32'd0;
        else if (!pc_en && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed checks for pipeline_ctrl hazard priority, forwarding, timeout and reset.
module tb_pipeline_ctrl;

    logic        clk, rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, me_rd, wb_rd;
    logic        ex_dm_rd, me_ru_wr, wb_ru_wr, ex_branch_taken, me_dm_req, dm_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en;
    logic        if_id_flush, id_ex_flush, me_wb_bubble, mem_err;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cycles;
    logic [4:0]  en;
    logic [2:0]  fl;
    logic        st;
    logic [7:0]  wcnt;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_dm_rd(ex_dm_rd),
        .me_rd(me_rd), .me_ru_wr(me_ru_wr), .wb_rd(wb_rd), .wb_ru_wr(wb_ru_wr),
        .ex_branch_taken(ex_branch_taken), .me_dm_req(me_dm_req), .dm_ready(dm_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_me_en(ex_me_en), .me_wb_en(me_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .me_wb_bubble(me_wb_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    assign en   = {pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en};
    assign fl   = {if_id_flush, id_ex_flush, me_wb_bubble};
    assign st   = dut.state;
    assign wcnt = dut.wait_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_dm_rd = 0;
        me_rd = 0; me_ru_wr = 0; wb_rd = 0; wb_ru_wr = 0;
        ex_branch_taken = 0; me_dm_req = 0; dm_ready = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        // Inputs that would otherwise forward and stall must be masked in reset.
        me_rd = 7; me_ru_wr = 1; ex_rs1 = 7; ex_rs2 = 7; me_dm_req = 1;
        #2;
        chk("rst_en", 32'(en), 32'h00);
        chk("rst_fl", 32'(fl), 32'h0);
        chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'h0);
        chk("rst_sc", stall_cycles, 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        tick();
        idle_inputs();
        rst_n = 1'b1;
        #1;
        chk("idle_en", 32'(en), 32'h1F);
        chk("idle_fl", 32'(fl), 32'h0);
        tick();
        chk("idle_sc", stall_cycles, 32'd0);

        // Load-use on rs2
        ex_dm_rd = 1; ex_rd = 5; id_rs2 = 5;
        #1;
        chk("lu_en", 32'(en), 32'h07);
        chk("lu_fl", 32'(fl), 32'h2);
        tick();
        chk("lu_sc", stall_cycles, 32'd1);
        // Load to x0 never stalls; load-use via rs1 does
        ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        #1;
        chk("lu_x0_en", 32'(en), 32'h1F);
        ex_rd = 9; id_rs1 = 9;
        #1;
        chk("lu_rs1_en", 32'(en), 32'h07);
        // Branch beats load-use
        ex_branch_taken = 1;
        #1;
        chk("br_lu_en", 32'(en), 32'h1F);
        chk("br_lu_fl", 32'(fl), 32'h6);
        idle_inputs();
        tick();
        chk("br_sc", stall_cycles, 32'd1);

        // Memory wait: 3 frozen cycles then ready
        me_dm_req = 1; dm_ready = 0;
        #1;
        chk("mw_en", 32'(en), 32'h01);
        chk("mw_fl", 32'(fl), 32'h1);
        tick();
        chk("mw_state", 32'(st), 32'd1);
        tick();
        tick();
        chk("mw_cnt", 32'(wcnt), 32'd3);
        dm_ready = 1;
        #1;
        chk("mw_rdy_en", 32'(en), 32'h1F);
        chk("mw_rdy_fl", 32'(fl), 32'h0);
        tick();
        chk("mw_run", 32'(st), 32'd0);
        chk("mw_sc", stall_cycles, 32'd4);
        idle_inputs();

        // Branch suppressed by memory stall, then taken once memory completes
        ex_branch_taken = 1; me_dm_req = 1; dm_ready = 0;
        #1;
        chk("sim_en", 32'(en), 32'h01);
        chk("sim_fl", 32'(fl), 32'h1);
        tick();
        dm_ready = 1;
        #1;
        chk("sim2_en", 32'(en), 32'h1F);
        chk("sim2_fl", 32'(fl), 32'h6);
        tick();
        chk("sim_sc", stall_cycles, 32'd5);
        idle_inputs();

        // Timeout with MEM_TIMEOUT=4
        me_dm_req = 1; dm_ready = 0;
        repeat (4) tick();
        chk("to_cnt4", 32'(wcnt), 32'd4);
        chk("to_noerr", 32'(mem_err), 32'd0);
        tick();
        chk("to_err", 32'(mem_err), 32'd1);
        chk("to_run", 32'(st), 32'd0);
        me_dm_req = 0;
        tick();
        tick();
        chk("to_sticky", 32'(mem_err), 32'd1);
        chk("to_sc", stall_cycles, 32'd10);

        // Forwarding
        me_rd = 7; wb_rd = 7; ex_rs1 = 7; me_ru_wr = 1; wb_ru_wr = 1;
        #1;
        chk("fwd_me_wins", 32'(fwd_a), 32'd2);
        ex_rs1 = 0; me_rd = 0; wb_rd = 0;
        #1;
        chk("fwd_x0", 32'(fwd_a), 32'd0);
        me_rd = 3; wb_rd = 7; ex_rs2 = 7;
        #1;
        chk("fwd_b_wb", 32'(fwd_b), 32'd1);
        ex_rs2 = 3;
        #1;
        chk("fwd_b_me", 32'(fwd_b), 32'd2);
        me_ru_wr = 0;
        #1;
        chk("fwd_b_nowr", 32'(fwd_b), 32'd0);
        idle_inputs();

        // Reset asserted mid-wait
        me_dm_req = 1; dm_ready = 0;
        tick();
        tick();
        chk("rmw_wait", 32'(st), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rmw_en", 32'(en), 32'h00);
        chk("rmw_fl", 32'(fl), 32'h0);
        chk("rmw_sc", stall_cycles, 32'd0);
        chk("rmw_cnt", 32'(wcnt), 32'd0);
        chk("rmw_err", 32'(mem_err), 32'd0);
        chk("rmw_state", 32'(st), 32'd0);
        idle_inputs();
        #2 rst_n = 1'b1;
        tick();
        chk("rmw_run", 32'(st), 32'd0);
        chk("rmw_en2", 32'(en), 32'h1F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, meaning the maximum number of consecutive data-memory wait cycles before an error (legal range 1..255).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-005 SHALL have ports ex_rs1, ex_rs2, ex_rd  in  5 each  sources and destination of the instruction in EX; ex_dm_rd  in  1  EX instruction is a load.
REQ-006 SHALL have ports me_rd  in  5 and me_ru_wr  in  1  ME destination and register-write flag; wb_rd  in  5 and wb_ru_wr  in  1  the same for WB.
REQ-007 SHALL have port ex_branch_taken  in  1  branch or jump resolved taken in EX.
REQ-008 SHALL have ports me_dm_req  in  1  ME instruction accesses data memory; dm_ready  in  1  data memory completes the access this cycle.
REQ-009 SHALL have ports pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en  out  1 each  pipeline-register load enables.
REQ-010 SHALL have ports if_id_flush, id_ex_flush, me_wb_bubble  out  1 each  load a NOP/bubble instead of the incoming data.
REQ-011 SHALL have ports fwd_a, fwd_b  out  2 each  ALU operand forward select: 00 register file, 01 WB, 10 ME.
REQ-012 SHALL have ports mem_err  out  1  sticky timeout flag; stall_cycles  out  32  count of frozen-PC cycles.

Function
REQ-013 SHALL implement FSM states RUN and MEM_WAIT, plus an 8-bit wait counter.
REQ-014 In RUN, if me_dm_req=1 and dm_ready=0, the FSM SHALL move to MEM_WAIT and set the wait counter to 1.
REQ-015 In MEM_WAIT, dm_ready=1 SHALL return the FSM to RUN; otherwise the wait counter SHALL increment.
REQ-016 In MEM_WAIT, a wait counter equal to MEM_TIMEOUT with dm_ready=0 SHALL set mem_err=1 and return the FSM to RUN.
REQ-017 mem_err SHALL be cleared only by reset.
REQ-018 Memory stall condition SHALL be (me_dm_req=1 and dm_ready=0), evaluated in both states; while true, pc_en, if_id_en, id_ex_en and ex_me_en SHALL be 0.
REQ-019 While the memory stall condition is true, me_wb_en SHALL be 1 and me_wb_bubble SHALL be 1.
REQ-020 Branch flush SHALL apply when ex_branch_taken=1 and no memory stall: all enables 1, if_id_flush=1, id_ex_flush=1.
REQ-021 Load-use stall SHALL apply when ex_dm_rd=1, ex_rd!=0, ex_rd equals id_rs1 or id_rs2, and neither memory stall nor branch flush applies.
REQ-022 On a load-use stall: pc_en=0, if_id_en=0, id_ex_flush=1, and all other enables 1.
REQ-023 Priority SHALL be memory stall > branch flush > load-use stall; a suppressed branch is re-evaluated next cycle because EX is held.
REQ-024 Otherwise all enables SHALL be 1 and all flush/bubble outputs SHALL be 0.
REQ-025 Control outputs SHALL be combinational functions of the current state and inputs (same-cycle response, zero latency).
REQ-026 fwd_a SHALL be 10 if me_ru_wr=1, me_rd!=0 and me_rd=ex_rs1; else 01 if wb_ru_wr=1, wb_rd!=0 and wb_rd=ex_rs1; else 00.
REQ-027 fwd_b SHALL follow the REQ-026 rule with ex_rs2; ME SHALL win when ME and WB both match.
REQ-028 stall_cycles SHALL increment on each rising edge where pc_en=0, saturating at 0xFFFFFFFF.

Reset
REQ-029 rst_n=0 SHALL immediately force: state RUN, wait counter 0, mem_err 0, stall_cycles 0.
REQ-030 While rst_n=0, all enables, flush and bubble outputs SHALL be 0 and fwd_a=fwd_b=00.
REQ-031 Reset asserted during MEM_WAIT SHALL abort the wait; after release, operation resumes in RUN.

Verification
REQ-032 Load-use: ex_dm_rd=1, ex_rd=5, id_rs2=5 -> pc_en=0, if_id_en=0, id_ex_flush=1 for one cycle; stall_cycles 0->1.
REQ-033 Memory wait: me_dm_req=1, dm_ready=0 for 3 cycles then 1 -> 3 frozen cycles with me_wb_bubble=1, then RUN, stall_cycles=3.
REQ-034 Simultaneous events: ex_branch_taken=1 plus memory stall -> freeze only; next cycle, with dm_ready=1 -> if_id_flush=id_ex_flush=1.
REQ-035 Timeout: MEM_TIMEOUT=4, dm_ready held 0 -> mem_err=1 after the 4th wait cycle, FSM in RUN, mem_err stays 1.
REQ-036 Forwarding: me_rd=wb_rd=ex_rs1=7, both write flags 1 -> fwd_a=10; with ex_rs1=0 -> fwd_a=00.
REQ-037 Reset mid-wait: rst_n=0 during MEM_WAIT -> outputs zero immediately, counters 0; after release -> state RUN.
